// File: rtl/alu_pkg.sv
// Shared definitions for the bitwise ALU and its front-end arbiter.
// Purpose: op code and arbiter state enums, ALU width constants, and the
//          op-code legality check used when forming the response.
// Contents:
//   ALU_DATA_W / ALU_OP_W : operand/result width and op code width
//   alu_op_e              : AND, NAND, OR, NOR, XOR, XNOR (codes 0..5)
//   arb_state_e           : IDLE, EXEC, RESP
//   is_legal_op()         : 1 for op codes 0..5, 0 for 6 and 7
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_OP_W   = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Codes 6 and 7 have no ALU function behind them.
  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker (purely combinational).
// Purpose: choose the first asserted request searching upward from ptr+1,
//          wrapping modulo N_REQ, so the last winner has lowest priority.
// Ports:
//   req : request vector, one bit per requester
//   ptr : index of the most recent winner
//   gid : chosen index (0 when no request is set)
//   any : at least one request is set
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic [GID_W-1:0] gid,
  output logic             any
);

  logic [GID_W-1:0] idx;

  // Walk offsets from the far end toward ptr+1 so the nearest set bit
  // after ptr is the last one written and therefore wins.
  always_comb begin
    gid = '0;
    idx = '0;
    any = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GID_W'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        gid = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbiter sharing one external combinational bitwise ALU among N_REQ requesters.
// Purpose: round-robin grant of request handshakes, registered operands
//          driving the ALU, registered result returned on a per-requester
//          response channel. One operation in flight at a time.
// Handshake: a request transfers on a rising edge where req_valid[i] and
//   req_ready[i] are both high; a response transfers on a rising edge where
//   rsp_valid[i] and rsp_ready[i] are both high. req_ready is only raised in
//   IDLE and only for the chosen requester; rsp_valid, rsp_result and rsp_err
//   hold steady until the response transfers.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake, one bit per requester
//   req_x/req_y/req_op     : packed per-requester operands and op code
//   alu_x/alu_y/alu_op     : registered operands to the external ALU
//   alu_result             : combinational result from the external ALU
//   rsp_valid/rsp_ready    : response handshake, one bit per requester
//   rsp_result/rsp_err     : shared response data, qualified by rsp_valid
//   busy                   : high whenever the arbiter is not in IDLE
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_x,
  input  logic [N_REQ*DATA_W-1:0] req_y,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]       alu_x,
  output logic [DATA_W-1:0]       alu_y,
  output logic [OP_W-1:0]         alu_op,
  input  logic [DATA_W-1:0]       alu_result,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int GID_W = $clog2(N_REQ);

  arb_state_e        state_q,      state_d;
  logic [GID_W-1:0]  rr_ptr_q,     rr_ptr_d;
  logic [GID_W-1:0]  gid_q,        gid_d;
  logic [DATA_W-1:0] x_q,          x_d;
  logic [DATA_W-1:0] y_q,          y_d;
  logic [OP_W-1:0]   op_q,         op_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_err_q,    rsp_err_d;
  logic [N_REQ-1:0]  rsp_valid_q,  rsp_valid_d;
  logic              busy_q,       busy_d;

  logic [GID_W-1:0]  pick_gid;
  logic              pick_any;
  logic              op_legal;

  rr_pick #(
    .N_REQ (N_REQ),
    .GID_W (GID_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gid (pick_gid),
    .any (pick_any)
  );

  assign op_legal = is_legal_op(op_q);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gid_d        = gid_q;
    x_d          = x_q;
    y_d          = y_q;
    op_d         = op_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready    = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          // Accept the winner; its operands as presented this cycle are used.
          req_ready = N_REQ'(1) << pick_gid;
          x_d       = req_x[int'(pick_gid)*DATA_W +: DATA_W];
          y_d       = req_y[int'(pick_gid)*DATA_W +: DATA_W];
          op_d      = req_op[int'(pick_gid)*OP_W +: OP_W];
          gid_d     = pick_gid;
          rr_ptr_d  = pick_gid;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU inputs have been stable from x_q/y_q/op_q for this whole cycle.
        rsp_err_d    = !op_legal;
        rsp_result_d = op_legal ? alu_result : '0;
        rsp_valid_d  = N_REQ'(1) << gid_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // Only the owning requester's ready completes the response.
        if (rsp_ready[gid_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= GID_W'(N_REQ - 1);
      gid_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      op_q         <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gid_q        <= gid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      op_q         <= op_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_x      = x_q;
  assign alu_y      = y_q;
  assign alu_op     = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed cases plus randomized traffic.
// Requests go through per-requester command queues; when a command is
// presented on the request port its expected {err, result} is queued.
// A negedge monitor tracks grants with a round-robin model and pops/compares
// responses as they complete.
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_x;
  logic [N*DW-1:0] req_y;
  logic [N*OW-1:0] req_op;
  logic [DW-1:0]   alu_x;
  logic [DW-1:0]   alu_y;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_result;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_result;
  logic            rsp_err;
  logic            busy;

  alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_op     (req_op),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- external ALU ----------------
  // Illegal codes return a non-zero pattern so result zeroing is visible.
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_x & alu_y;
      3'd1:    alu_result = ~(alu_x & alu_y);
      3'd2:    alu_result = alu_x | alu_y;
      3'd3:    alu_result = ~(alu_x | alu_y);
      3'd4:    alu_result = alu_x ^ alu_y;
      3'd5:    alu_result = ~(alu_x ^ alu_y);
      default: alu_result = alu_x ^ 8'h5A;
    endcase
  end

  // ---------------- reference model ----------------
  function automatic logic [8:0] ref_rsp(input logic [7:0] x, input logic [7:0] y,
                                         input logic [2:0] op);
    logic [7:0] r;
    if (op > 3'd5) return {1'b1, 8'h00};
    unique case (op)
      3'd0: r = x & y;
      3'd1: r = ~(x & y);
      3'd2: r = x | y;
      3'd3: r = ~(x | y);
      3'd4: r = x ^ y;
      default: r = ~(x ^ y);
    endcase
    return {1'b0, r};
  endfunction

  // First valid requester after the previous winner, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (((v >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  // ---------------- scoreboard state ----------------
  int         n_vec;
  int         n_fail;
  logic [8:0] exp_q[N][$];
  logic [18:0] cmd_q[N][$];
  int         grant_log[$];
  int         gcyc_log[$];
  bit         rand_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic push_cmd(input int i, input logic [7:0] x, input logic [7:0] y,
                          input logic [2:0] op);
    cmd_q[i].push_back({op, x, y});
  endtask

  // ---------------- driver ----------------
  logic [N-1:0] acc;
  initial begin
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_op    = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
          cmd_q[i].delete();
          exp_q[i].delete();
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            req_valid[i] = 1'b0;
          end else if (req_valid[i] && rand_mode) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
              // Withdraw before grant: the request simply vanishes.
              req_valid[i] = 1'b0;
              void'(exp_q[i].pop_back());
            end else if (r == 1) begin
              // Change operands while waiting: the new values must be used.
              logic [7:0] nx, ny;
              logic [2:0] no;
              nx = 8'($urandom_range(0, 255));
              ny = 8'($urandom_range(0, 255));
              no = 3'($urandom_range(0, 7));
              req_x[i*DW +: DW]  = nx;
              req_y[i*DW +: DW]  = ny;
              req_op[i*OW +: OW] = no;
              void'(exp_q[i].pop_back());
              exp_q[i].push_back(ref_rsp(nx, ny, no));
            end
          end
          if (!req_valid[i] && cmd_q[i].size() != 0) begin
            logic [18:0] c;
            c = cmd_q[i].pop_front();
            req_x[i*DW +: DW]  = c[15:8];
            req_y[i*DW +: DW]  = c[7:0];
            req_op[i*OW +: OW] = c[18:16];
            req_valid[i]       = 1'b1;
            exp_q[i].push_back(ref_rsp(c[15:8], c[7:0], c[18:16]));
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int           cyc;
  bit           m_busy;
  int           m_gcyc;
  int           m_gid;
  int           m_ptr;
  int           mon_g;
  logic [N-1:0] mon_rdy;
  logic [N-1:0] mon_rv;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = N - 1;
    end else begin
      mon_rdy = '0;
      mon_g   = -1;
      if (!m_busy) begin
        mon_g = pick(req_valid, m_ptr);
        if (mon_g >= 0) mon_rdy = 4'd1 << mon_g;
      end
      chk("req_ready", 32'(req_ready), 32'(mon_rdy));
      chk("busy", 32'(busy), 32'(m_busy));
      mon_rv = '0;
      if (m_busy && cyc >= m_gcyc + 2) mon_rv = 4'd1 << m_gid;
      chk("rsp_valid", 32'(rsp_valid), 32'(mon_rv));
      if (mon_rv != '0) begin
        if (exp_q[m_gid].size() == 0) begin
          chk("rsp_expected_present", 32'(0), 32'(1));
        end else begin
          chk("rsp_result", 32'(rsp_result), 32'(exp_q[m_gid][0][7:0]));
          chk("rsp_err", 32'(rsp_err), 32'(exp_q[m_gid][0][8]));
          if (rsp_ready[m_gid]) begin
            void'(exp_q[m_gid].pop_front());
            m_busy = 1'b0;
          end
        end
      end
      if (mon_rdy != '0) begin
        m_busy = 1'b1;
        m_gcyc = cyc;
        m_gid  = mon_g;
        m_ptr  = mon_g;
        grant_log.push_back(mon_g);
        gcyc_log.push_back(cyc);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      #1;
      done = (req_valid == '0) && !m_busy;
      for (int i = 0; i < N; i++)
        if (cmd_q[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
    end
    chk("drain_done", 32'(done), 32'(1));
  endtask

  task automatic wait_rsp(input int i, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      seen = rsp_valid[i];
    end
    chk("rsp_valid_seen", 32'(seen), 32'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_outputs_zero();
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_alu_x", 32'(alu_x), 32'(0));
    chk("rst_alu_y", 32'(alu_y), 32'(0));
    chk("rst_alu_op", 32'(alu_op), 32'(0));
    chk("rst_rsp_result", 32'(rsp_result), 32'(0));
    chk("rst_rsp_err", 32'(rsp_err), 32'(0));
  endtask

  // ---------------- main sequence ----------------
  int exp_order[8];

  initial begin
    n_vec     = 0;
    n_fail    = 0;
    rand_mode = 1'b0;
    rsp_ready = '1;
    rst_n     = 1'b0;
    #3;
    chk_outputs_zero();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Directed single-requester operations.
    push_cmd(0, 8'h15, 8'hC7, 3'd0);
    push_cmd(0, 8'h15, 8'hC7, 3'd1);
    wait_drain(100);
    push_cmd(2, 8'h95, 8'h6F, 3'd2);
    push_cmd(2, 8'h95, 8'h6F, 3'd3);
    wait_drain(100);
    push_cmd(1, 8'h59, 8'h6C, 3'd4);
    push_cmd(1, 8'h59, 8'h6C, 3'd5);
    push_cmd(1, 8'h6C, 8'h6C, 3'd5);
    wait_drain(100);

    // All four continuously valid after reset: 0,1,2,3,0,1,2,3, 3 cycles apart.
    do_reset();
    grant_log.delete();
    gcyc_log.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        push_cmd(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 3'($urandom_range(0, 5)));
    wait_drain(200);
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("grant_count", 32'(grant_log.size()), 32'(8));
    for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
      chk("grant_order", 32'(grant_log[k]), 32'(exp_order[k]));
      if (k > 0) chk("grant_spacing", 32'(gcyc_log[k] - gcyc_log[k-1]), 32'(3));
    end

    // Backpressure on requester 0 with requester 1 pending.
    rsp_ready[0] = 1'b0;
    push_cmd(0, 8'hA3, 8'h3C, 3'd4);
    @(posedge clk);
    #2;
    push_cmd(1, 8'h0F, 8'hF3, 3'd2);
    wait_rsp(0, 20);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rsp_ready[0] = 1'b1;
    wait_drain(100);

    // Illegal op codes, then a legal one.
    push_cmd(2, 8'hFF, 8'hFF, 3'd6);
    push_cmd(2, 8'hFF, 8'h00, 3'd7);
    push_cmd(2, 8'hF0, 8'h3C, 3'd0);
    wait_drain(100);

    // Asynchronous reset while a response is held.
    rsp_ready[0] = 1'b0;
    push_cmd(0, 8'h77, 8'h11, 3'd2);
    wait_rsp(0, 20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero();
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    grant_log.delete();
    push_cmd(3, 8'h12, 8'h34, 3'd4);
    push_cmd(0, 8'h56, 8'h78, 3'd4);
    wait_drain(100);
    chk("post_reset_grants", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() >= 1) chk("post_reset_first", 32'(grant_log[0]), 32'(0));

    // Randomized traffic with random response backpressure.
    rand_mode = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #2;
      rsp_ready = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        if (cmd_q[i].size() < 2 && $urandom_range(0, 3) == 0)
          push_cmd(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   3'($urandom_range(0, 7)));
    end
    rand_mode = 1'b0;
    rsp_ready = '1;
    wait_drain(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1);
  end

endmodule
